mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port unified memory of the multicycle core between two requesters: port 0 (CPU fetch/load/store sequencer) and port 1 (DMA/program loader). It accepts held request/acknowledge transactions, grants the memory round-robin, drives the memory's address/write-data/write-enable, and returns registered read data with a one-cycle acknowledge pulse. An optional lock gives a requester back-to-back accesses up to a burst limit.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single-port unified memory, with optional locked bursts.
// Define MEM_ARB_ALIGN_CHK_EN to reject misaligned accesses with an error acknowledge.
module mem_arb_port #(
  parameter int DW = 16
) (
  input  logic          sel,
  input  logic          ack_st,
  input  logic          err_q,
  input  logic [DW-1:0] rdata_q,
  output logic          ack,
  output logic          err,
  output logic [DW-1:0] rdata
);
  assign ack   = ack_st & sel;
  assign err   = ack_st & sel & err_q;
  assign rdata = rdata_q;
endmodule

module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic          m0_err,
  output logic          m1_err,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t state, state_d;
  logic owner, owner_d, last_owner, last_d;
  logic [BW-1:0] burst_cnt, burst_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic err_q, err_d;

  logic [1:0]         req, we, lock;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic [1:0]         ack, err;
  logic [1:0][DW-1:0] rdata;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign lock  = {m1_lock, m0_lock};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  logic          own_req, own_we, own_lock, misal, in_acc;
  logic [AW-1:0] own_addr;
  assign own_req  = req[owner];
  assign own_we   = we[owner];
  assign own_lock = lock[owner];
  assign own_addr = addr[owner];
  assign in_acc   = (state == ACCESS);

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign misal = |own_addr[1:0];
`else
  assign misal = 1'b0;
`endif

  // reset gating keeps the write strobe from lingering while the async clear settles
  assign mem_a  = in_acc ? own_addr : '0;
  assign mem_wd = in_acc ? wdata[owner] : '0;
  assign mem_we = in_acc & own_we & own_req & ~misal & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_d;
      burst_cnt  <= burst_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last_owner;
    burst_d = burst_cnt;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state)
      IDLE: if (|req) begin
        // on a tie the port that did not go last wins
        owner_d = (&req) ? ~last_owner : req[1];
        burst_d = '0;
        state_d = ACCESS;
      end
      ACCESS: if (!own_req) begin
        state_d = IDLE;
      end else begin
        rdata_d = (own_we | misal) ? '0 : mem_rd;
        err_d   = misal;
        last_d  = owner;
        state_d = ACK;
      end
      ACK: if (own_lock && burst_cnt < BW'(BURST_MAX-1)) begin
        burst_d = burst_cnt + 1'b1;
        state_d = ACCESS;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    mem_arb_port #(.DW(DW)) u_port (
      .sel    (owner == 1'(i)),
      .ack_st (state == ACK),
      .err_q  (err_q),
      .rdata_q(rdata_q),
      .ack    (ack[i]),
      .err    (err[i]),
      .rdata  (rdata[i])
    );
  end

  assign m0_ack   = ack[0];
  assign m1_ack   = ack[1];
  assign m0_err   = err[0];
  assign m1_err   = err[1];
  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory behind the arbiter.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0, m0_lock = 0, m1_lock = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, m0_err, m1_err, mem_we;
  logic [15:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

  logic [15:0] mem [0:255];
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  mem_arbiter #(.AW(16), .DW(16), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Unlocked single access; entered just after a posedge with the arbiter idle.
  task automatic xfer(input int p, input logic w, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic er, output int cyc);
    logic hit;
    if (p == 0) begin m0_req = 1; m0_we = w; m0_addr = a; m0_wdata = wd; end
    else        begin m1_req = 1; m1_we = w; m1_addr = a; m1_wdata = wd; end
    cyc = 0;
    hit = 0;
    while (!hit && cyc < 20) begin
      @(negedge clk);
      cyc++;
      hit = (p == 0) ? m0_ack : m1_ack;
      chk("xfer_other_ack", (p == 0) ? m1_ack : m0_ack, 0);
    end
    chk("xfer_timeout", hit, 1);
    rd = (p == 0) ? m0_rdata : m1_rdata;
    er = (p == 0) ? m0_err : m1_err;
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    logic [15:0] rd;
    logic er;
    int cyc, k;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[1] = 16'h000C;
    mem[4] = 16'h5555;

    #12;
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    @(negedge clk); reset = 0;

    // reset hits mid-ACCESS of a write: strobe drops at once, no write, no ack
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'h1234;
    @(posedge clk); #2;
    chk("rst_acc_we", mem_we, 1);
    chk("rst_acc_a", mem_a, 16'h0010);
    reset = 1; #1;
    chk("rst_we_drop", mem_we, 0);
    chk("rst_ack_drop", m0_ack, 0);
    m0_req = 0; m0_we = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_word4", mem[4], 16'h5555);
    chk("rst_m0_ack2", m0_ack, 0);
    chk("rst_m1_ack2", m1_ack, 0);

    // tie from reset: m0 first, then strict alternation, 3 cycles per grant
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 16'h0004; m1_req = 1; m1_addr = 16'h0008;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("rr_m0_ack_c%0d", c), m0_ack, (c % 6 == 2));
      chk($sformatf("rr_m1_ack_c%0d", c), m1_ack, (c % 6 == 5));
      if (c == 2) chk("rr_m0_rdata", m0_rdata, 16'h000C);
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1;

    xfer(0, 0, 16'h0004, 0, rd, er, cyc);
    chk("rd_latency", cyc, 3);
    chk("rd_data", rd, 16'h000C);

    // locked burst of 6 writes by m1; m0 read arrives during the first access
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 16'h0001;
    k = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk($sformatf("bu_m1_ack_c%0d", c), m1_ack,
          (c == 2 || c == 4 || c == 6 || c == 8 || c == 14 || c == 16));
      chk($sformatf("bu_m0_ack_c%0d", c), m0_ack, (c == 11));
      if (c == 9 || c == 12) chk($sformatf("bu_idle_we_c%0d", c), mem_we, 0);
      if (c == 11) begin
        chk("bu_m0_rdata", m0_rdata, 16'h000C);
        m0_req = 0;
      end
      if (c == 1) begin m0_req = 1; m0_we = 0; m0_addr = 16'h0004; end
      if (m1_ack) begin
        k++;
        m1_addr = m1_addr + 16'd4;
        m1_wdata = m1_wdata + 16'd1;
        if (k == 6) begin m1_req = 0; m1_lock = 0; m1_we = 0; end
      end
    end
    for (int i = 0; i < 6; i++) chk($sformatf("bu_word%0d", 8 + i), mem[8 + i], 16'(i + 1));
    @(posedge clk); #1;

    xfer(1, 0, 16'h0020, 0, rd, er, cyc);
    chk("m1_rd_data", rd, 16'h0001);

    xfer(0, 1, 16'h0008, 16'hBEEF, rd, er, cyc);
    chk("wr_rdata_zero", rd, 0);
    chk("wr_err", er, 0);
    chk("wr_word2", mem[2], 16'hBEEF);
    xfer(0, 0, 16'h0008, 0, rd, er, cyc);
    chk("wr_rd_back", rd, 16'hBEEF);

    xfer(0, 1, 16'h0006, 16'hAAAA, rd, er, cyc);
    chk("mis_rdata", rd, 0);
`ifdef MEM_ARB_ALIGN_CHK_EN
    chk("mis_err", er, 1);
    chk("mis_word1", mem[1], 16'h000C);
`else
    chk("mis_err", er, 0);
    chk("mis_word1", mem[1], 16'hAAAA);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
